// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution result collector:
// state encodings, output-map geometry and saturation limits.
package conv_pkg;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;

  function automatic int out_dim(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/conv_result_ram.sv
// Simple dual-port feature-map buffer: synchronous write, registered read
// that holds its output while rd_en is low.
module conv_result_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 576,
  parameter int ADDR_W     = 10
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_result_collector.sv
// Collects one quantized OUT_DIM x OUT_DIM feature map from the convolver
// and drains it in raster order over a valid/ready stream.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int IN_WIDTH    = 32,
  parameter int FRAC_BITS   = 8,
  parameter int RELU_EN     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [4:0]                   out_row,
  output logic [4:0]                   out_col,
  output logic                         out_last,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         busy
);

  localparam int OUT_DIM = out_dim(IMAGE_SIZE, KERNEL_SIZE);
  localparam int DEPTH   = OUT_DIM * OUT_DIM;
  localparam int ADDR_W  = addr_w(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_PTR  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  END_PTR   = CNT_W'(DEPTH);
  localparam logic [4:0]        LAST_IDX  = 5'(OUT_DIM - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'(sat_hi(DATA_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = IN_WIDTH'(sat_lo(DATA_WIDTH));

  function automatic logic signed [DATA_WIDTH-1:0] quantize(input logic signed [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH-1:0] s;
    s = x >>> FRAC_BITS;
    if (RELU_EN != 0 && s[IN_WIDTH-1]) s = '0;
    if (s > SAT_HI)      s = SAT_HI;
    else if (s < SAT_LO) s = SAT_LO;
    return s[DATA_WIDTH-1:0];
  endfunction

  logic [0:0]                   state;
  logic [ADDR_W-1:0]            wr_addr_p0;
  logic signed [DATA_WIDTH-1:0] q_p0;
  logic                         wr_fire, wr_last;
  logic [CNT_W-1:0]             rd_ptr_p0;
  logic [4:0]                   rd_row_p0, rd_col_p0;
  logic                         vld_p1, last_p1;
  logic [4:0]                   row_p1, col_p1;
  logic signed [DATA_WIDTH-1:0] rd_data_p1;
  logic                         advance, issue;

  assign q_p0    = quantize(in_data);
  assign wr_fire = (state == COLLECT) && in_valid;
  assign wr_last = wr_fire && (wr_addr_p0 == LAST_ADDR);
  assign advance = !out_valid || out_ready;
  // Address 0 is prefetched on the final write so the first element is out two cycles later.
  assign issue   = advance && (wr_last || ((state == DRAIN) && (rd_ptr_p0 != END_PTR)));
  assign busy    = (state == DRAIN);

  conv_result_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_fire),
    .wr_addr(wr_addr_p0),
    .wr_data(q_p0),
    .rd_en  (issue),
    .rd_addr(rd_ptr_p0[ADDR_W-1:0]),
    .rd_data(rd_data_p1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      wr_addr_p0 <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      rd_ptr_p0  <= '0;
      rd_row_p0  <= '0;
      rd_col_p0  <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      row_p1     <= '0;
      col_p1     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
    end else begin
      // p0: write side
      frame_done <= wr_last;
      if (wr_fire) wr_addr_p0 <= wr_last ? '0 : wr_addr_p0 + ADDR_W'(1);
      if (wr_last) state <= DRAIN;
      if ((state == DRAIN) && in_valid) overrun <= 1'b1;

      // p0 -> p1: read issue with coordinate tags
      if (issue) begin
        vld_p1    <= 1'b1;
        row_p1    <= rd_row_p0;
        col_p1    <= rd_col_p0;
        last_p1   <= (rd_ptr_p0 == LAST_PTR);
        rd_ptr_p0 <= rd_ptr_p0 + CNT_W'(1);
        if (rd_col_p0 == LAST_IDX) begin
          rd_col_p0 <= '0;
          rd_row_p0 <= rd_row_p0 + 5'd1;
        end else begin
          rd_col_p0 <= rd_col_p0 + 5'd1;
        end
      end else if (advance) begin
        vld_p1 <= 1'b0;
      end

      // p1 -> p2: output register
      if (advance) begin
        out_valid <= vld_p1;
        out_last  <= vld_p1 && last_p1;
        if (vld_p1) begin
          out_data <= rd_data_p1;
          out_row  <= row_p1;
          out_col  <= col_p1;
        end
      end

      if ((state == DRAIN) && out_valid && out_ready && out_last) begin
        state     <= COLLECT;
        rd_ptr_p0 <= '0;
        rd_row_p0 <= '0;
        rd_col_p0 <= '0;
      end
    end
  end

endmodule
